shift_seq_ctrl: RTL

Multi-cycle sequencer for the ALU shift path. It accepts one shift request through a valid/ready handshake and applies the five power-of-two shift stages one per clock: stage k shifts by 2^k when shamt[k] is set. It returns the result through a second valid/ready handshake. The block sits beside the combinational shift logic in the ALU and serves multi-cycle execute slots, where a single-cycle 32-bit barrel shifter does not meet timing. It adds arithmetic right shift to the existing logical left/right operations.

---
 rtl/shift_seq_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: one request in, five power-of-two shift stages
// (one per clock), one result out, with valid/ready handshakes on both sides.
module shift_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [4:0]  in_shamt,
    input  logic [1:0]  in_op,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_PASS = 2'b10;
    localparam logic [1:0] OP_SRA  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  stage_q, stage_d;
    logic [31:0] work_q,  work_d;
    logic [4:0]  shamt_q, shamt_d;
    logic [1:0]  op_q,    op_d;

    // One shift stage of 2^stage positions; SRA replicates the current sign bit.
    function automatic logic [31:0] shift_stage(input logic [31:0] w,
                                                input logic [1:0]  op,
                                                input logic [2:0]  stage);
        logic [4:0]  amt;
        logic [31:0] r;
        amt = 5'd1 << stage;
        case (op)
            OP_SLL:  r = w << amt;
            OP_SRL:  r = w >> amt;
            OP_SRA:  r = $unsigned($signed(w) >>> amt);
            default: r = w;
        endcase
        return r;
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            stage_q <= 3'd0;
            work_q  <= 32'd0;
            shamt_q <= 5'd0;
            op_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            work_q  <= work_d;
            shamt_q <= shamt_d;
            op_q    <= op_d;
        end
    end

    // Next-state and datapath update; flush beats any acceptance or progress.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        work_d  = work_q;
        shamt_d = shamt_q;
        op_d    = op_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        shamt_d = in_shamt;
                        op_d    = in_op;
                        stage_d = 3'd0;
                        work_d  = in_a;
                        if ((in_shamt == 5'd0) || (in_op == OP_PASS)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_SHIFT;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_SHIFT: begin
                    if (shamt_q[stage_q]) begin
                        work_d = shift_stage(work_q, op_q, stage_q);
                    end else begin
                        work_d = work_q;
                    end
                    if (stage_q == 3'd4) begin
                        stage_d = 3'd0;
                        state_d = S_DONE;
                    end else begin
                        stage_d = stage_q + 3'd1;
                        state_d = S_SHIFT;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_data  = work_q;

endmodule
